dictionary_cam_seq: RTL and testbench
=====================================

// Module: dictionary_cam_seq
// PURPOSE
//  Loadable, parametrised successor to the compression dictionary: a 2**KEY_WIDTH-entry table
//  with per-entry valid bits, runtime load/clear, a 1-cycle registered decompress (key->value)
//  port and a multi-cycle, LANES-wide compress search (value->key) behind a valid/ready handshake.
//  Sits between the dictionary loader and the instruction compressor/decompressor paths.
// PARAMETERS
//  KEY_WIDTH  4  compressed index width; table depth DEPTH = 2**KEY_WIDTH
//  VAL_WIDTH  8  uncompressed field width
//  LANES      4  entries compared per search cycle; must divide DEPTH; G = DEPTH/LANES groups
// PORTS
//  clock           in   1            single clock, all state updates on posedge
//  reset           in   1            synchronous, active-high
//  wr_en           in   1            load entry wr_key with wr_val, set its valid bit
//  wr_key          in   KEY_WIDTH    entry index to load
//  wr_val          in   VAL_WIDTH    value to load
//  clr             in   1            invalidate all entries (contents kept, valid bits cleared)
//  dec_en          in   1            decompress request
//  dec_key         in   KEY_WIDTH    key to look up
//  dec_valid       out  1            dec_val/dec_hit valid this cycle
//  dec_val         out  VAL_WIDTH    stored value (0 when entry invalid)
//  dec_hit         out  1            entry dec_key was valid
//  cmp_req_valid   in   1            compress search request
//  cmp_req_ready   out  1            block can accept request (state IDLE)
//  cmp_val         in   VAL_WIDTH    value to search for; captured on accept
//  cmp_resp_valid  out  1            search result present; held until taken
//  cmp_resp_ready  in   1            consumer takes result
//  cmp_hit         out  1            a valid entry matched
//  cmp_key         out  KEY_WIDTH    lowest matching index (0 on miss)
//  num_valid       out  KEY_WIDTH+1  count of valid entries
// BEHAVIOUR
//  - Reset: all valid bits 0, num_valid=0, dec_valid/dec_hit/dec_val=0, state IDLE,
//    cmp_resp_valid=0, cmp_hit=0, cmp_key=0. Reset mid-search abandons the search, no response.
//  - Storage is flops; data contents are not reset, only valid bits.
//  - Write: on wr_en, mem[wr_key]<=wr_val, valid[wr_key]<=1; num_valid +1 only if entry was invalid.
//  - clr: all valid<=0, num_valid<=0. clr and wr_en same cycle: clr wins, write dropped entirely.
//  - Decompress: 1-cycle latency; dec_valid<=dec_en; dec_val<=valid?mem:0; dec_hit<=valid.
//    Same-cycle write to dec_key: read returns OLD value/valid (read-before-write).
//  - Compress FSM: IDLE -> SEARCH -> RESP -> IDLE.
//    IDLE: cmp_req_ready=1; on cmp_req_valid capture cmp_val, grp<=0, go SEARCH.
//    SEARCH: compare entries grp*LANES..grp*LANES+LANES-1 (valid && mem==captured value);
//      on any match latch lowest matching index, cmp_hit<=1, go RESP; else if grp==G-1
//      latch cmp_hit<=0, cmp_key<=0, go RESP; else grp<=grp+1.
//    RESP: cmp_resp_valid=1, cmp_hit/cmp_key stable; on cmp_resp_ready go IDLE (no accept that cycle).
//  - Latency: request accepted cycle 0 -> hit in group g gives cmp_resp_valid in cycle g+2;
//    miss gives cycle G+1. Max one request in flight.
//  - Writes/clr during SEARCH apply immediately; groups not yet scanned see new contents,
//    already-scanned groups are not rescanned. Response is never altered once in RESP.
//  - Duplicate values: lowest index wins, across and within groups.
// TESTING
//  1 reset; load k3=0xA5, k9=0x3C -> num_valid=2; dec k3 -> next cycle dec_val=0xA5, dec_hit=1.
//  2 dec k7 (never loaded) -> dec_hit=0, dec_val=0; rewrite k3=0x11 -> num_valid stays 2.
//  3 search 0x3C (G=4) accepted cycle 0 -> cmp_resp_valid cycle 4, cmp_hit=1, cmp_key=9;
//    search 0xFF -> cycle 5, cmp_hit=0, cmp_key=0.
//  4 load k2=k12=0x55; search 0x55 -> cmp_key=2; hold cmp_resp_ready=0 5 cycles -> outputs stable,
//    cmp_req_ready=0 throughout.
//  5 clr with wr_en(k1=0x77) same cycle -> num_valid=0, search 0x77 misses.
//  6 reset asserted during SEARCH -> next cycle IDLE, cmp_resp_valid=0, num_valid=0, ready=1.

Source files
------------

// File: rtl/dictionary_cam_seq_if.sv
// Bus bundle for dictionary_cam_seq: load/clear, decompress and compress
// handshake signals. The master drives requests, the slave is the dictionary.
interface dictionary_cam_seq_if #(
  parameter int unsigned KEY_WIDTH = 4,
  parameter int unsigned VAL_WIDTH = 8
);
  logic                 wr_en;
  logic [KEY_WIDTH-1:0] wr_key;
  logic [VAL_WIDTH-1:0] wr_val;
  logic                 clr;
  logic                 dec_en;
  logic [KEY_WIDTH-1:0] dec_key;
  logic                 dec_valid;
  logic [VAL_WIDTH-1:0] dec_val;
  logic                 dec_hit;
  logic                 cmp_req_valid;
  logic                 cmp_req_ready;
  logic [VAL_WIDTH-1:0] cmp_val;
  logic                 cmp_resp_valid;
  logic                 cmp_resp_ready;
  logic                 cmp_hit;
  logic [KEY_WIDTH-1:0] cmp_key;
  logic [KEY_WIDTH:0]   num_valid;

  modport master (
    output wr_en, wr_key, wr_val, clr, dec_en, dec_key,
           cmp_req_valid, cmp_val, cmp_resp_ready,
    input  dec_valid, dec_val, dec_hit, cmp_req_ready,
           cmp_resp_valid, cmp_hit, cmp_key, num_valid
  );

  modport slave (
    input  wr_en, wr_key, wr_val, clr, dec_en, dec_key,
           cmp_req_valid, cmp_val, cmp_resp_ready,
    output dec_valid, dec_val, dec_hit, cmp_req_ready,
           cmp_resp_valid, cmp_hit, cmp_key, num_valid
  );
endinterface

// File: rtl/dictionary_cam_seq.sv
// Loadable compression dictionary: 2**KEY_WIDTH flop entries with valid bits,
// 1-cycle registered decompress (key->value) and a LANES-wide multi-cycle
// compress search (value->lowest matching key) behind a valid/ready handshake.
module dictionary_cam_seq #(
  parameter int unsigned KEY_WIDTH = 4,
  parameter int unsigned VAL_WIDTH = 8,
  parameter int unsigned LANES     = 4
) (
  input logic                  clock,
  input logic                  reset,
  dictionary_cam_seq_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << KEY_WIDTH;
  localparam int unsigned G     = DEPTH / LANES;
  localparam int unsigned GRP_W = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t               state;
  logic [VAL_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic [VAL_WIDTH-1:0] key_val;
  logic [GRP_W-1:0]     grp;
  logic                 grp_hit;
  logic [KEY_WIDTH-1:0] grp_key;
  logic [KEY_WIDTH-1:0] lane_idx;
  logic                 last_grp;
  logic                 do_write;

  // clr has priority over a same-cycle write, which is dropped entirely
  assign do_write = bus.wr_en && !bus.clr;
  assign last_grp = (grp == GRP_W'(G - 1));

  // Entry data storage; contents survive reset and clr, only valid bits are cleared
  always_ff @(posedge clock) begin
    if (do_write) mem[bus.wr_key] <= bus.wr_val;
  end

  // Valid bits, occupancy count and the registered decompress port (read-before-write)
  always_ff @(posedge clock) begin
    if (reset) begin
      valid         <= '0;
      bus.num_valid <= '0;
      bus.dec_valid <= 1'b0;
      bus.dec_hit   <= 1'b0;
      bus.dec_val   <= '0;
    end else begin
      if (bus.clr) begin
        valid         <= '0;
        bus.num_valid <= '0;
      end else if (bus.wr_en) begin
        valid[bus.wr_key] <= 1'b1;
        if (!valid[bus.wr_key]) bus.num_valid <= bus.num_valid + 1'b1;
      end
      bus.dec_valid <= bus.dec_en;
      bus.dec_hit   <= valid[bus.dec_key];
      bus.dec_val   <= valid[bus.dec_key] ? mem[bus.dec_key] : '0;
    end
  end

  // Compare the current group's lanes; first match in ascending order is the lowest index
  always_comb begin
    grp_hit  = 1'b0;
    grp_key  = '0;
    lane_idx = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx = KEY_WIDTH'(32'(grp) * LANES + l);
      if (!grp_hit && valid[lane_idx] && mem[lane_idx] == key_val) begin
        grp_hit = 1'b1;
        grp_key = lane_idx;
      end
    end
  end

  // Compress search FSM with registered handshake and result outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      bus.cmp_req_ready  <= 1'b1;
      bus.cmp_resp_valid <= 1'b0;
      bus.cmp_hit        <= 1'b0;
      bus.cmp_key        <= '0;
      key_val            <= '0;
      grp                <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmp_req_valid) begin
            key_val           <= bus.cmp_val;
            grp               <= '0;
            bus.cmp_req_ready <= 1'b0;
            state             <= SEARCH;
          end
        end
        SEARCH: begin
          if (grp_hit) begin
            bus.cmp_hit        <= 1'b1;
            bus.cmp_key        <= grp_key;
            bus.cmp_resp_valid <= 1'b1;
            state              <= RESP;
          end else if (last_grp) begin
            bus.cmp_hit        <= 1'b0;
            bus.cmp_key        <= '0;
            bus.cmp_resp_valid <= 1'b1;
            state              <= RESP;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        RESP: begin
          if (bus.cmp_resp_ready) begin
            bus.cmp_resp_valid <= 1'b0;
            bus.cmp_req_ready  <= 1'b1;
            state              <= IDLE;
          end
        end
        default: begin
          bus.cmp_resp_valid <= 1'b0;
          bus.cmp_req_ready  <= 1'b1;
          state              <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dictionary_cam_seq.sv
// Directed self-checking bench for dictionary_cam_seq (KEY_WIDTH=4, LANES=4, G=4).
module tb_dictionary_cam_seq;
  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   cyc;

  dictionary_cam_seq_if #(.KEY_WIDTH(4), .VAL_WIDTH(8)) bus ();

  dictionary_cam_seq #(.KEY_WIDTH(4), .VAL_WIDTH(8), .LANES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [3:0] k, input logic [7:0] v);
    bus.wr_en = 1'b1; bus.wr_key = k; bus.wr_val = v;
    step();
    bus.wr_en = 1'b0;
  endtask

  // present a request in cycle 0 and leave the DUT in cycle 1
  task automatic start_search(input logic [7:0] v);
    check("req_ready_before", 32'(bus.cmp_req_ready), 1);
    bus.cmp_req_valid = 1'b1; bus.cmp_val = v;
    step();
    bus.cmp_req_valid = 1'b0;
    cyc = 1;
  endtask

  // wait (bounded) for the response; cyc ends as the cycle index of cmp_resp_valid
  task automatic wait_resp(input string tag, input int exp_cyc, input logic hit, input logic [3:0] key);
    while (!bus.cmp_resp_valid && cyc < 20) begin
      check({tag, "_req_ready_busy"}, 32'(bus.cmp_req_ready), 0);
      step();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_hit"}, 32'(bus.cmp_hit), 32'(hit));
    check({tag, "_key"}, 32'(bus.cmp_key), 32'(key));
  endtask

  task automatic take_resp(input string tag);
    bus.cmp_resp_ready = 1'b1;
    step();
    bus.cmp_resp_ready = 1'b0;
    check({tag, "_resp_dropped"}, 32'(bus.cmp_resp_valid), 0);
    check({tag, "_ready_back"}, 32'(bus.cmp_req_ready), 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_key = '0; bus.wr_val = '0; bus.clr = 0;
    bus.dec_en = 0; bus.dec_key = '0;
    bus.cmp_req_valid = 0; bus.cmp_val = '0; bus.cmp_resp_ready = 0;
    step(); step();
    reset = 1'b0;
    check("rst_num_valid", 32'(bus.num_valid), 0);
    check("rst_dec_valid", 32'(bus.dec_valid), 0);
    check("rst_dec_val", 32'(bus.dec_val), 0);
    check("rst_req_ready", 32'(bus.cmp_req_ready), 1);
    check("rst_resp_valid", 32'(bus.cmp_resp_valid), 0);
    check("rst_cmp_hit", 32'(bus.cmp_hit), 0);
    check("rst_cmp_key", 32'(bus.cmp_key), 0);

    // 1: loads and a decompress hit
    write(4'd3, 8'hA5);
    write(4'd9, 8'h3C);
    check("num_valid_2", 32'(bus.num_valid), 2);
    bus.dec_en = 1; bus.dec_key = 4'd3;
    step();
    bus.dec_en = 0;
    check("dec3_valid", 32'(bus.dec_valid), 1);
    check("dec3_val", 32'(bus.dec_val), 32'hA5);
    check("dec3_hit", 32'(bus.dec_hit), 1);
    step();
    check("dec_valid_drop", 32'(bus.dec_valid), 0);

    // 2: decompress miss, read-before-write, rewrite keeps count
    bus.dec_en = 1; bus.dec_key = 4'd7;
    step();
    check("dec7_hit", 32'(bus.dec_hit), 0);
    check("dec7_val", 32'(bus.dec_val), 0);
    bus.dec_key = 4'd3;
    bus.wr_en = 1; bus.wr_key = 4'd3; bus.wr_val = 8'h11;
    step();
    bus.wr_en = 0;
    check("rbw_old_val", 32'(bus.dec_val), 32'hA5);
    check("rewrite_num_valid", 32'(bus.num_valid), 2);
    step();
    bus.dec_en = 0;
    check("dec3_new_val", 32'(bus.dec_val), 32'h11);

    // 3: hit in group 2, then a miss
    start_search(8'h3C);
    wait_resp("s3C", 4, 1'b1, 4'd9);
    take_resp("s3C");
    start_search(8'hFF);
    wait_resp("sFF", 5, 1'b0, 4'd0);
    take_resp("sFF");

    // 4: duplicates across groups, response held under backpressure
    write(4'd2, 8'h55);
    write(4'd12, 8'h55);
    check("num_valid_4", 32'(bus.num_valid), 4);
    start_search(8'h55);
    wait_resp("s55", 2, 1'b1, 4'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_resp_valid", 32'(bus.cmp_resp_valid), 1);
      check("hold_key", 32'(bus.cmp_key), 2);
      check("hold_hit", 32'(bus.cmp_hit), 1);
      check("hold_req_ready", 32'(bus.cmp_req_ready), 0);
    end
    take_resp("s55");

    // duplicates within one group: index 13 beats 14 regardless of load order
    write(4'd14, 8'h66);
    write(4'd13, 8'h66);
    start_search(8'h66);
    wait_resp("s66", 5, 1'b1, 4'd13);
    take_resp("s66");

    // write during SEARCH lands in a not-yet-scanned group and is found
    start_search(8'h99);
    write(4'd15, 8'h99);
    cyc++;
    wait_resp("s99", 5, 1'b1, 4'd15);
    take_resp("s99");
    check("num_valid_7", 32'(bus.num_valid), 7);

    // 5: clr beats a same-cycle write
    bus.clr = 1; bus.wr_en = 1; bus.wr_key = 4'd1; bus.wr_val = 8'h77;
    step();
    bus.clr = 0; bus.wr_en = 0;
    check("clr_num_valid", 32'(bus.num_valid), 0);
    bus.dec_en = 1; bus.dec_key = 4'd1;
    step();
    bus.dec_en = 0;
    check("clr_dec1_hit", 32'(bus.dec_hit), 0);
    start_search(8'h77);
    wait_resp("s77", 5, 1'b0, 4'd0);
    take_resp("s77");

    // 6: reset mid-search abandons it
    write(4'd0, 8'h42);
    start_search(8'hEE);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_req_ready", 32'(bus.cmp_req_ready), 1);
    check("midrst_resp_valid", 32'(bus.cmp_resp_valid), 0);
    check("midrst_num_valid", 32'(bus.num_valid), 0);
    check("midrst_hit", 32'(bus.cmp_hit), 0);
    check("midrst_key", 32'(bus.cmp_key), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_resp", 32'(bus.cmp_resp_valid), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
